// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the datapath-to-memory stall bridge.
`timescale 1ns/1ps
package mem_bus_pkg;

   // Value returned to the datapath when a read cannot complete
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } bridge_state_t;

   // Access captured at request time; address kept as a word index
   typedef struct packed {
      logic        we;
      logic [29:0] waddr;
      logic [31:0] wdata;
   } mem_hold_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter: flags the cycle in which LIMIT busy cycles are used up.
`timescale 1ns/1ps
module wait_timer #(
   parameter int unsigned LIMIT = 16   // must be at least 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   // Count enabled cycles; clear has priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // Terminal when the current cycle is the LIMIT-th counted cycle
   assign tc_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stall_bridge.sv
// Stalls the multi-cycle datapath while one access runs on a wait-state bus.
`timescale 1ns/1ps
module mem_stall_bridge
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        bus_err,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   bridge_state_t state;
   mem_hold_t     hold;
   logic          timer_clear;
   logic          timer_en;
   logic          timer_tc;

   // Timer restarts every time BUSY is entered and counts unanswered cycles
   assign timer_clear = (state != ST_BUSY);
   assign timer_en    = (state == ST_BUSY) && !mem_ready;

   wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_wait_timer (
      .clk    (CLK),
      .rst    (Reset),
      .clear  (timer_clear),
      .enable (timer_en),
      .tc_c   (timer_tc)
   );

   // Bus address and data come straight from the holding register
   assign mem_addr  = {hold.waddr, 2'b00};
   assign mem_wdata = hold.wdata;

   // Stall covers the request cycle and every bus wait cycle
   assign cpu_stall = ((state == ST_IDLE) && cpu_req) || (state == ST_BUSY);

   // Access sequencer; DONE and ERROR are single-cycle acknowledge states
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         hold      <= '0;
         cpu_rdata <= '0;
         bus_err   <= 1'b0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  if (cpu_addr[1:0] == 2'b00) begin
                     hold.we    <= cpu_we;
                     hold.waddr <= cpu_addr[31:2];
                     hold.wdata <= cpu_wdata;
                     mem_valid  <= 1'b1;
                     mem_we     <= cpu_we;
                     state      <= ST_BUSY;
                  end else begin
                     // Misaligned: fail without touching the bus
                     bus_err <= 1'b1;
                     if (!cpu_we) begin
                        cpu_rdata <= ERR_DATA;
                     end
                     state <= ST_ERROR;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  // Completion wins over a simultaneous timeout
                  if (!hold.we) begin
                     cpu_rdata <= mem_rdata;
                  end
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  state     <= ST_DONE;
               end else if (timer_tc) begin
                  bus_err <= 1'b1;
                  if (!hold.we) begin
                     cpu_rdata <= ERR_DATA;
                  end
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  state     <= ST_ERROR;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            ST_ERROR: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Scoreboard bench for mem_stall_bridge: stimulus queues expected results,
// a negedge monitor checks bus-side values and each completed access.
`timescale 1ns/1ps
module tb_mem_stall_bridge;

   localparam int unsigned TIMEOUT  = 16;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
   localparam int          NEVER    = 1000;

   logic        CLK;
   logic        Reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        bus_err;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mis;
      logic [31:0] rdata;
      logic        err;
      int          stall;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 0;
   int          stall_cnt = 0;
   logic [31:0] model_rdata = '0;
   logic        model_err = 1'b0;

   mem_stall_bridge #(
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (ERR_DATA)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .bus_err   (bus_err),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One access: model the outcome, queue it, then play the bus side.
   // lat = wait cycles before mem_ready; lat >= TIMEOUT means never answered.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int lat, input logic [31:0] rdata);
      exp_t e;
      int   busy;
      logic err;
      e.mis = (addr[1:0] != 2'b00);
      if (e.mis)                    busy = 0;
      else if (lat < int'(TIMEOUT)) busy = lat + 1;
      else                          busy = int'(TIMEOUT);
      err = e.mis || (lat >= int'(TIMEOUT));
      if (!we) model_rdata = err ? ERR_DATA : rdata;
      model_err = model_err | err;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = model_rdata;
      e.err   = model_err;
      e.stall = busy + 1;
      exp_q.push_back(e);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      for (int c = 1; c <= busy; c++) begin
         @(posedge CLK); #1;
         mem_ready = (c == lat + 1);
         mem_rdata = (c == lat + 1) ? rdata : $urandom;
      end
      @(posedge CLK); #1;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      repeat (n) begin
         mem_ready = 1'($urandom);
         mem_rdata = $urandom;
         @(posedge CLK); #1;
      end
   endtask

   // Monitor: bus-side values while valid, then the access outcome
   always @(negedge CLK) begin
      if (Reset || !mon_en) begin
         stall_cnt = 0;
      end else begin
         if (mem_valid) begin
            if (exp_q.size() == 0 || exp_q[0].mis) begin
               chk("mem_valid_unexpected", 32'(mem_valid), 32'd0);
            end else begin
               chk("mem_addr", mem_addr, exp_q[0].addr & 32'hFFFF_FFFC);
               chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
               chk("mem_wdata", mem_wdata, exp_q[0].wdata);
            end
         end
         if (cpu_req && cpu_stall) begin
            stall_cnt++;
         end else if (cpu_req) begin
            if (exp_q.size() == 0) begin
               chk("completion_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
               chk("cpu_rdata", cpu_rdata, e.rdata);
               chk("bus_err", 32'(bus_err), 32'(e.err));
               chk("done_mem_valid", 32'(mem_valid), 32'd0);
            end
            stall_cnt = 0;
         end else begin
            chk("idle_quiet", {30'd0, cpu_stall, mem_valid}, 32'd0);
         end
      end
   end

   initial begin
      logic [31:0] a;
      int          sel;
      int          lat;
      int          gap;
      Reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      Reset  = 1'b0;
      mon_en = 1'b1;

      // Directed: fastest read, waited write, back-to-back, timeout boundary
      txn(1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
      idle(2);
      txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3, 32'h0);
      idle(1);
      txn(1'b0, 32'h0000_0020, 32'h0, 1, 32'hA5A5_0001);
      txn(1'b0, 32'h0000_0024, 32'h0, 0, 32'h0BAD_F00D);
      idle(1);
      txn(1'b0, 32'h0000_0030, 32'h0, int'(TIMEOUT) - 1, 32'h7777_0000);
      idle(1);
      txn(1'b0, 32'h0000_0034, 32'h0, NEVER, 32'h0);
      idle(2);
      txn(1'b0, 32'h0000_0038, 32'h0, 0, 32'h1111_2222);
      idle(1);

      // Reset in the middle of a write's wait cycles
      mon_en    = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0000_0040;
      cpu_wdata = 32'h5555_AAAA;
      mem_ready = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("midbusy_valid", 32'(mem_valid), 32'd1);
      chk("midbusy_we", 32'(mem_we), 32'd1);
      chk("midbusy_err_before", 32'(bus_err), 32'(model_err));
      #2;
      Reset   = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_mem_we", 32'(mem_we), 32'd0);
      chk("arst_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("arst_cpu_rdata", cpu_rdata, 32'd0);
      chk("arst_bus_err", 32'(bus_err), 32'd0);
      @(posedge CLK); #1;
      Reset       = 1'b0;
      model_rdata = '0;
      model_err   = 1'b0;
      mon_en      = 1'b1;

      // Misaligned accesses right after reset release
      txn(1'b0, 32'h0000_0003, 32'h0, 0, 32'h0);
      idle(1);
      txn(1'b1, 32'h0000_0042, 32'h1357_9BDF, 0, 32'h0);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(7) != 0) a[1:0] = 2'b00;
         sel = int'($urandom_range(9));
         if (sel < 6)      lat = int'($urandom_range(4));
         else if (sel < 8) lat = int'(TIMEOUT) - 2 + int'($urandom_range(2));
         else              lat = NEVER;
         txn(1'($urandom), a, $urandom, lat, $urandom);
         gap = int'($urandom_range(2));
         if (gap > 0) idle(gap);
      end

      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stall_bridge.md
MEM_STALL_BRIDGE -- requirements
Module: mem_stall_bridge

Interface
REQ-001 The block SHALL be a single-clock unit between the multi-cycle datapath's data-memory port (upstream) and a wait-state memory bus (downstream); one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- TIMEOUT, 16, maximum BUSY cycles without mem_ready before error
- ERR_DATA, 32'hDEAD_BEEF, value returned on cpu_rdata for an errored read
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous active-high reset
- cpu_req  in  1  datapath requests an access; held until cpu_stall low
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, registered
- cpu_stall  out  1  controller holds its state while high
- bus_err  out  1  sticky error flag
- mem_valid  out  1  bus request valid
- mem_we  out  1  bus write strobe
- mem_addr  out  32  word-aligned bus address
- mem_wdata  out  32  bus write data
- mem_ready  in  1  bus completes the access this cycle
- mem_rdata  in  32  bus read data, valid with mem_ready

Function
REQ-004 The FSM SHALL have states IDLE, BUSY, DONE and ERROR.
REQ-005 IDLE: cpu_req=1 with cpu_addr[1:0]=0 SHALL latch we/addr/wdata into holding registers and go to BUSY; with cpu_addr[1:0]!=0 it SHALL go to ERROR without any bus transaction.
REQ-006 cpu_stall SHALL be combinationally 1 when (IDLE and cpu_req) or BUSY, else 0.
REQ-007 BUSY: mem_valid=1; mem_we, mem_addr={addr[31:2],2'b00} and mem_wdata SHALL come from the holding registers and stay stable until mem_ready.
REQ-008 BUSY with mem_ready=1: a read SHALL capture mem_rdata into cpu_rdata; next state DONE.
REQ-009 A wait counter (width clog2(TIMEOUT+1)) SHALL clear on entering BUSY and increment each BUSY cycle without mem_ready; reaching TIMEOUT SHALL go to ERROR; mem_ready in the same cycle as terminal count wins (DONE).
REQ-010 DONE and ERROR SHALL last exactly one cycle with cpu_stall=0, then return to IDLE unconditionally; cpu_req high in that cycle is the completing request, not a new one.
REQ-011 ERROR SHALL set bus_err=1 (sticky until Reset) and, for a read, load cpu_rdata with ERR_DATA; writes leave cpu_rdata unchanged.
REQ-012 cpu_rdata SHALL hold its value until the next completed or errored read.
REQ-013 mem_ready outside BUSY SHALL be ignored.
REQ-014 Minimum access SHALL be 3 cycles: request in IDLE (cycle 0), BUSY cycle 1 with mem_ready, DONE cycle 2 with stall low.

Reset
REQ-015 Reset SHALL asynchronously force IDLE, counter 0, cpu_rdata 0, bus_err 0, holding registers 0; mem_valid and mem_we SHALL fall immediately, including mid-BUSY.
REQ-016 After Reset deassertion, the first rising edge SHALL treat cpu_req normally.

Structure
REQ-017 The state encoding and ERR_DATA default SHALL live in a shared mem_bus package.
REQ-018 The timeout counter SHALL be a sub-module wait_timer (clear, enable, terminal-count output).

Verification
REQ-019 Read, mem_ready on first BUSY cycle, mem_rdata=32'h1234_5678 -> stall high 2 cycles, cpu_rdata=32'h1234_5678 in cycle 2, bus_err=0.
REQ-020 Write addr 32'h0000_0010, data 32'hCAFE_F00D, mem_ready after 3 wait cycles -> mem_* stable for 4 BUSY cycles, stall low in cycle 5.
REQ-021 Read with mem_ready never asserted, TIMEOUT=16 -> ERROR after 16 BUSY cycles, cpu_rdata=32'hDEAD_BEEF, bus_err=1 and sticky.
REQ-022 Read addr 32'h0000_0003 -> mem_valid never asserted, ERROR in cycle 1, bus_err=1.
REQ-023 Reset asserted mid-BUSY -> mem_valid, cpu_stall, cpu_rdata, bus_err all 0 without a clock edge.
REQ-024 Back-to-back reads with cpu_req held high -> second transaction enters BUSY only after the DONE cycle and an IDLE cycle.
